tl45_operand_read_fwd: RTL and testbench

Parametrised register-read / operand-forwarding stage between decode and the ALU. It generalises register read to N forwarding buses, configurable data width and register count, and valid/ready handshaking. It adds load-use hazard detection: a stall FSM holds the producer and emits bubbles while a needed result is still pending.

---
 rtl/tl45_operand_read_fwd.sv | 169 ++++++++++++++++
 tb/tb_tl45_operand_read_fwd.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl45_operand_read_fwd.sv
// Register-read / operand-forwarding stage: resolves operands across NFWD buses, stalls on pending results.
// Optional stall-cycle counter enabled by defining TL45_RR_PERF_EN.
module tl45_operand_read_fwd #(
    parameter int          XLEN          = 32,
    parameter int          NREG          = 16,
    parameter int          NFWD          = 2,
    parameter logic [4:0]  BRANCH_OPCODE = 5'h0C,
    localparam int         AW            = $clog2(NREG)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [4:0]           i_opcode,
    input  logic                 i_ri,
    input  logic [AW-1:0]        i_dr,
    input  logic [AW-1:0]        i_sr1,
    input  logic [AW-1:0]        i_sr2,
    input  logic [XLEN-1:0]      i_imm,
    input  logic [XLEN-1:0]      i_pc,
    output logic [AW-1:0]        o_dprf_read_a1,
    output logic [AW-1:0]        o_dprf_read_a2,
    input  logic [XLEN-1:0]      i_dprf_d1,
    input  logic [XLEN-1:0]      i_dprf_d2,
    input  logic [NFWD-1:0]      i_fwd_valid,
    input  logic [NFWD-1:0]      i_fwd_pending,
    input  logic [NFWD*AW-1:0]   i_fwd_reg,
    input  logic [NFWD*XLEN-1:0] i_fwd_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [4:0]           o_opcode,
    output logic [AW-1:0]        o_dr,
    output logic [3:0]           o_jmp_cond,
    output logic [XLEN-1:0]      o_sr1_val,
    output logic [XLEN-1:0]      o_sr2_val,
    output logic [XLEN-1:0]      o_target_address_offset,
    output logic [XLEN-1:0]      o_pc,
    output logic                 o_hazard,
    output logic [31:0]          o_stall_count
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    typedef struct packed {
        logic            haz;
        logic [XLEN-1:0] val;
    } opnd_t;

    // The first matching bus decides, so a pending young producer masks an older ready one.
    function automatic opnd_t resolve(
        input logic [AW-1:0]        s,
        input logic [XLEN-1:0]      dprf,
        input logic [NFWD-1:0]      fv,
        input logic [NFWD-1:0]      fp,
        input logic [NFWD*AW-1:0]   fr,
        input logic [NFWD*XLEN-1:0] fd
    );
        opnd_t r;
        logic  hit;
        r.haz = 1'b0;
        r.val = dprf;
        hit   = 1'b0;
        if (s == '0) begin
            r.val = '0;
        end else begin
            for (int k = 0; k < NFWD; k++) begin
                if (!hit && fv[k] && fr[k*AW +: AW] == s) begin
                    hit   = 1'b1;
                    r.haz = fp[k];
                    if (!fp[k]) r.val = fd[k*XLEN +: XLEN];
                end
            end
        end
        return r;
    endfunction

    state_t          state, state_nxt;
    opnd_t           src1, src2;
    logic [XLEN-1:0] sr2_val;
    logic            hazard_now;
    logic            accept;

    assign o_dprf_read_a1 = i_sr1;
    assign o_dprf_read_a2 = i_sr2;

    always_comb begin
        src1       = resolve(i_sr1, i_dprf_d1, i_fwd_valid, i_fwd_pending, i_fwd_reg, i_fwd_data);
        src2       = resolve(i_sr2, i_dprf_d2, i_fwd_valid, i_fwd_pending, i_fwd_reg, i_fwd_data);
        sr2_val    = i_ri ? i_imm : src2.val;
        hazard_now = i_valid && (src1.haz || (!i_ri && src2.haz));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= RUN;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (hazard_now)  state_nxt = STALL;
            STALL:   if (!hazard_now) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (i_flush) state_nxt = RUN;
    end

    always_comb begin
        o_hazard = (state == STALL);
        o_ready  = (state == RUN) && (!o_valid || i_ready) && !hazard_now && !i_flush;
    end

    assign accept = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid                 <= 1'b0;
            o_opcode                <= '0;
            o_dr                    <= '0;
            o_jmp_cond              <= '0;
            o_sr1_val               <= '0;
            o_sr2_val               <= '0;
            o_target_address_offset <= '0;
            o_pc                    <= '0;
        end else if (i_flush) begin
            o_valid                 <= 1'b0;
            o_opcode                <= '0;
            o_dr                    <= '0;
            o_jmp_cond              <= '0;
            o_sr1_val               <= '0;
            o_sr2_val               <= '0;
            o_target_address_offset <= '0;
            o_pc                    <= '0;
        end else if (accept) begin
            o_valid                 <= 1'b1;
            o_opcode                <= i_opcode;
            o_sr1_val               <= src1.val;
            o_sr2_val               <= sr2_val;
            o_target_address_offset <= i_imm;
            o_pc                    <= i_pc;
            if (i_opcode == BRANCH_OPCODE) begin
                o_dr       <= '0;
                o_jmp_cond <= i_dr[3:0];
            end else begin
                o_dr       <= i_dr;
                o_jmp_cond <= '0;
            end
        end else if (o_valid && i_ready) begin
            // Drained with nothing new: emit a bubble, other fields keep their last value.
            o_valid  <= 1'b0;
            o_opcode <= '0;
        end
    end

`ifdef TL45_RR_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)            stall_cnt <= '0;
        else if (state == STALL)   stall_cnt <= stall_cnt + 32'd1;
    end

    assign o_stall_count = stall_cnt;
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_tl45_operand_read_fwd.sv
// Directed bench for tl45_operand_read_fwd: forwarding priority, r0/immediate, stall FSM, handshake, flush, reset.
module tb_tl45_operand_read_fwd;
    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int NFWD = 2;
    localparam int AW   = 4;
`ifdef TL45_RR_PERF_EN
    localparam logic [31:0] EXP_STALLS = 32'd4;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

    logic                 i_clk = 1'b0;
    logic                 i_reset_n, i_flush, i_valid, i_ri, i_ready;
    logic [4:0]           i_opcode;
    logic [AW-1:0]        i_dr, i_sr1, i_sr2;
    logic [XLEN-1:0]      i_imm, i_pc, i_dprf_d1, i_dprf_d2;
    logic [NFWD-1:0]      i_fwd_valid, i_fwd_pending;
    logic [NFWD*AW-1:0]   i_fwd_reg;
    logic [NFWD*XLEN-1:0] i_fwd_data;
    logic                 o_ready, o_valid, o_hazard;
    logic [AW-1:0]        o_dprf_read_a1, o_dprf_read_a2, o_dr;
    logic [4:0]           o_opcode;
    logic [3:0]           o_jmp_cond;
    logic [XLEN-1:0]      o_sr1_val, o_sr2_val, o_target_address_offset, o_pc;
    logic [31:0]          o_stall_count;

    int errors = 0;
    int checks = 0;

    tl45_operand_read_fwd #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .BRANCH_OPCODE(5'h0C)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_ri(i_ri), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2), .i_imm(i_imm),
        .i_pc(i_pc), .o_dprf_read_a1(o_dprf_read_a1), .o_dprf_read_a2(o_dprf_read_a2),
        .i_dprf_d1(i_dprf_d1), .i_dprf_d2(i_dprf_d2), .i_fwd_valid(i_fwd_valid),
        .i_fwd_pending(i_fwd_pending), .i_fwd_reg(i_fwd_reg), .i_fwd_data(i_fwd_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_opcode(o_opcode), .o_dr(o_dr), .o_jmp_cond(o_jmp_cond),
        .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val), .o_target_address_offset(o_target_address_offset),
        .o_pc(o_pc), .o_hazard(o_hazard), .o_stall_count(o_stall_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_valid       = 1'b0;
        i_ri          = 1'b0;
        i_fwd_valid   = '0;
        i_fwd_pending = '0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [AW-1:0] dr, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic ri, input logic [XLEN-1:0] imm,
                         input logic [XLEN-1:0] pc);
        i_valid = 1'b1; i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2;
        i_ri = ri; i_imm = imm; i_pc = pc;
        i_fwd_valid = '0; i_fwd_pending = '0;
    endtask

    task automatic bus(input int k, input logic v, input logic p, input logic [AW-1:0] r,
                       input logic [XLEN-1:0] d);
        i_fwd_valid[k]           = v;
        i_fwd_pending[k]         = p;
        i_fwd_reg[k*AW +: AW]    = r;
        i_fwd_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_opcode = '0; i_dr = '0; i_sr1 = '0; i_sr2 = '0; i_imm = '0; i_pc = '0;
        i_dprf_d1 = '0; i_dprf_d2 = '0; i_fwd_reg = '0; i_fwd_data = '0;
        idle();
        #2;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h exp 0", o_valid); end
        checks++; if (o_opcode !== 5'h0) begin errors++; $display("FAIL reset_opcode: got %0h exp 0", o_opcode); end
        checks++; if (o_sr1_val !== 32'h0) begin errors++; $display("FAIL reset_sr1: got %0h exp 0", o_sr1_val); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h exp 0", o_pc); end
        checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %0h exp 0", o_hazard); end
        checks++; if (o_stall_count !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0h exp 0", o_stall_count); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h exp 1", o_ready); end
        tick(); tick();
        i_reset_n = 1'b1;
    endtask

    task automatic test_stall();
        tick();
        issue(5'h01, 4'd2, 4'd5, 4'd0, 1'b0, 32'h0, 32'h100);
        i_dprf_d1 = 32'hDEAD;
        bus(1, 1'b1, 1'b1, 4'd5, 32'h0);
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_detect_ready: got %0h exp 0", o_ready); end
        checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL stall_detect_hazard: got %0h exp 0", o_hazard); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (o_hazard !== 1'b1 || o_ready !== 1'b0)
                begin errors++; $display("FAIL stall_pending%0d: hazard/ready got %0b%0b exp 10", c, o_hazard, o_ready); end
        end
        tick();
        bus(1, 1'b1, 1'b0, 4'd5, 32'h77);
        #1;
        checks++; if (o_hazard !== 1'b1 || o_ready !== 1'b0)
            begin errors++; $display("FAIL stall_penalty: hazard/ready got %0b%0b exp 10", o_hazard, o_ready); end
        tick();
        checks++; if (o_hazard !== 1'b0 || o_ready !== 1'b1)
            begin errors++; $display("FAIL stall_exit: hazard/ready got %0b%0b exp 01", o_hazard, o_ready); end
        tick();
        idle();
        #1;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_accept_valid: got %0h exp 1", o_valid); end
        checks++; if (o_sr1_val !== 32'h77) begin errors++; $display("FAIL stall_accept_sr1: got %0h exp 77", o_sr1_val); end
        checks++; if (o_stall_count !== EXP_STALLS)
            begin errors++; $display("FAIL stall_count: got %0d exp %0d", o_stall_count, EXP_STALLS); end
    endtask

    task automatic test_fwd_priority();
        tick();
        issue(5'h01, 4'd1, 4'd3, 4'd7, 1'b0, 32'h10, 32'h200);
        i_dprf_d1 = 32'hCC; i_dprf_d2 = 32'h22;
        bus(0, 1'b1, 1'b0, 4'd3, 32'hAA);
        bus(1, 1'b1, 1'b0, 4'd3, 32'hBB);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready: got %0h exp 1", o_ready); end
        checks++; if (o_dprf_read_a1 !== 4'd3 || o_dprf_read_a2 !== 4'd7)
            begin errors++; $display("FAIL fwd_dprf_addr: got %0h/%0h exp 3/7", o_dprf_read_a1, o_dprf_read_a2); end
        tick();
        issue(5'h01, 4'd1, 4'd3, 4'd9, 1'b0, 32'h0, 32'h204);
        bus(1, 1'b1, 1'b0, 4'd9, 32'hBB);
        #1;
        checks++; if (o_sr1_val !== 32'hAA) begin errors++; $display("FAIL fwd_prio_sr1: got %0h exp aa", o_sr1_val); end
        checks++; if (o_sr2_val !== 32'h22) begin errors++; $display("FAIL fwd_dprf_sr2: got %0h exp 22", o_sr2_val); end
        checks++; if (o_target_address_offset !== 32'h10)
            begin errors++; $display("FAIL fwd_offset: got %0h exp 10", o_target_address_offset); end
        tick();
        idle();
        #1;
        checks++; if (o_sr1_val !== 32'hCC) begin errors++; $display("FAIL fwd_nomatch_sr1: got %0h exp cc", o_sr1_val); end
        checks++; if (o_sr2_val !== 32'hBB) begin errors++; $display("FAIL fwd_bus1_sr2: got %0h exp bb", o_sr2_val); end
    endtask

    task automatic test_zero_imm();
        tick();
        issue(5'h01, 4'd1, 4'd0, 4'd0, 1'b0, 32'h0, 32'h300);
        i_dprf_d1 = 32'h99; i_dprf_d2 = 32'h98;
        bus(0, 1'b1, 1'b1, 4'd0, 32'h55);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL r0_no_hazard: got %0h exp 1", o_ready); end
        tick();
        issue(5'h01, 4'd1, 4'd0, 4'd5, 1'b1, 32'h1234, 32'h304);
        bus(0, 1'b1, 1'b1, 4'd5, 32'h0);
        #1;
        checks++; if (o_sr1_val !== 32'h0 || o_sr2_val !== 32'h0)
            begin errors++; $display("FAIL r0_value: got %0h/%0h exp 0/0", o_sr1_val, o_sr2_val); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL imm_no_hazard: got %0h exp 1", o_ready); end
        tick();
        idle();
        #1;
        checks++; if (o_sr2_val !== 32'h1234) begin errors++; $display("FAIL imm_sr2: got %0h exp 1234", o_sr2_val); end
    endtask

    task automatic test_branch();
        tick();
        issue(5'h0C, 4'h9, 4'd0, 4'd0, 1'b0, 32'h40, 32'h400);
        tick();
        issue(5'h01, 4'h9, 4'd0, 4'd0, 1'b0, 32'h0, 32'h404);
        #1;
        checks++; if (o_opcode !== 5'h0C || o_dr !== 4'h0 || o_jmp_cond !== 4'h9)
            begin errors++; $display("FAIL branch_fields: got op=%0h dr=%0h jc=%0h exp c/0/9", o_opcode, o_dr, o_jmp_cond); end
        tick();
        idle();
        #1;
        checks++; if (o_opcode !== 5'h01 || o_dr !== 4'h9 || o_jmp_cond !== 4'h0)
            begin errors++; $display("FAIL alu_fields: got op=%0h dr=%0h jc=%0h exp 1/9/0", o_opcode, o_dr, o_jmp_cond); end
    endtask

    task automatic test_back_to_back();
        tick();
        i_ready = 1'b0;
        issue(5'h02, 4'd3, 4'd0, 4'd0, 1'b0, 32'h0, 32'h500);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL hold_first_ready: got %0h exp 1", o_ready); end
        tick();
        issue(5'h03, 4'd4, 4'd0, 4'd0, 1'b0, 32'h0, 32'h504);
        #1;
        checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0)
            begin errors++; $display("FAIL hold_full: valid/ready got %0b%0b exp 10", o_valid, o_ready); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (o_pc !== 32'h500 || o_opcode !== 5'h02 || o_dr !== 4'd3 || o_ready !== 1'b0)
                begin errors++; $display("FAIL hold_stable%0d: pc=%0h op=%0h rdy=%0b exp 500/2/0", c, o_pc, o_opcode, o_ready); end
        end
        i_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %0h exp 1", o_ready); end
        tick();
        idle();
        #1;
        checks++; if (o_pc !== 32'h504 || o_opcode !== 5'h03 || o_valid !== 1'b1)
            begin errors++; $display("FAIL hold_next: pc=%0h op=%0h v=%0b exp 504/3/1", o_pc, o_opcode, o_valid); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_opcode !== 5'h0 || o_pc !== 32'h504)
            begin errors++; $display("FAIL bubble: v=%0b op=%0h pc=%0h exp 0/0/504", o_valid, o_opcode, o_pc); end
    endtask

    task automatic test_priority_hazard();
        tick();
        issue(5'h01, 4'd1, 4'd3, 4'd0, 1'b0, 32'h0, 32'h600);
        bus(0, 1'b1, 1'b1, 4'd3, 32'h0);
        bus(1, 1'b1, 1'b0, 4'd3, 32'hBB);
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL prio_pending_ready: got %0h exp 0", o_ready); end
        idle();
        tick();
        issue(5'h01, 4'd1, 4'd0, 4'd4, 1'b0, 32'h0, 32'h604);
        bus(1, 1'b1, 1'b1, 4'd4, 32'h0);
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL sr2_hazard_ready: got %0h exp 0", o_ready); end
        idle();
        tick();
        checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL valid_drop_run: got %0h exp 0", o_hazard); end
    endtask

    task automatic test_flush();
        tick();
        i_ready = 1'b0;
        issue(5'h04, 4'd2, 4'd0, 4'd0, 1'b0, 32'h0, 32'h700);
        tick();
        issue(5'h01, 4'd1, 4'd6, 4'd0, 1'b0, 32'h0, 32'h704);
        bus(0, 1'b1, 1'b1, 4'd6, 32'h0);
        tick();
        checks++; if (o_hazard !== 1'b1 || o_valid !== 1'b1)
            begin errors++; $display("FAIL flush_setup: hazard/valid got %0b%0b exp 11", o_hazard, o_valid); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        idle();
        #1;
        checks++; if (o_valid !== 1'b0 || o_opcode !== 5'h0 || o_pc !== 32'h0 || o_dr !== 4'h0)
            begin errors++; $display("FAIL flush_clear: v=%0b op=%0h pc=%0h dr=%0h exp 0", o_valid, o_opcode, o_pc, o_dr); end
        checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL flush_run: got %0h exp 0", o_hazard); end
        i_ready = 1'b1;
        tick();
        issue(5'h05, 4'd1, 4'd0, 4'd0, 1'b0, 32'h0, 32'h708);
        i_flush = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0h exp 0", o_ready); end
        tick();
        i_flush = 1'b0;
        idle();
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %0h exp 0", o_valid); end
    endtask

    task automatic test_async_reset();
        tick();
        i_ready = 1'b0;
        issue(5'h06, 4'd5, 4'd0, 4'd0, 1'b0, 32'h0, 32'h800);
        tick();
        issue(5'h01, 4'd1, 4'd6, 4'd0, 1'b0, 32'h0, 32'h804);
        bus(0, 1'b1, 1'b1, 4'd6, 32'h0);
        tick();
        checks++; if (o_hazard !== 1'b1 || o_valid !== 1'b1)
            begin errors++; $display("FAIL areset_setup: hazard/valid got %0b%0b exp 11", o_hazard, o_valid); end
        #1;
        i_reset_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_opcode !== 5'h0 || o_pc !== 32'h0 || o_dr !== 4'h0)
            begin errors++; $display("FAIL areset_clear: v=%0b op=%0h pc=%0h dr=%0h exp 0", o_valid, o_opcode, o_pc, o_dr); end
        checks++; if (o_hazard !== 1'b0 || o_stall_count !== 32'h0)
            begin errors++; $display("FAIL areset_fsm: hazard=%0b cnt=%0d exp 0/0", o_hazard, o_stall_count); end
        idle();
        tick();
        i_reset_n = 1'b1;
        i_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_fwd_priority();
        test_zero_imm();
        test_branch();
        test_back_to_back();
        test_priority_hazard();
        test_flush();
        test_async_reset();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end
endmodule
